// File: rtl/nibble_serial_adder.sv
// Multi-cycle adder: one 4-bit carry-select slice reused for every nibble,
// least significant nibble first, with the carry held in a flop.
module select_adder_4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);
  logic [2:0] lo;
  logic [2:0] hi0;
  logic [2:0] hi1;

  // Upper pair is precomputed for both carries and picked by the lower carry.
  assign lo  = {1'b0, a[1:0]} + {1'b0, b[1:0]} + {2'b00, cin};
  assign hi0 = {1'b0, a[3:2]} + {1'b0, b[3:2]};
  assign hi1 = {1'b0, a[3:2]} + {1'b0, b[3:2]} + 3'd1;

  assign s    = {(lo[2] ? hi1[1:0] : hi0[1:0]), lo[1:0]};
  assign cout = lo[2] ? hi1[2] : hi0[2];
endmodule

module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  output logic [WIDTH-1:0] S,
  output logic             cout,
  output logic             busy,
  output logic             done
);
  localparam int NIBBLES = WIDTH / 4;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [IW-1:0]   idx;
  logic            carry;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [3:0]      na;
  logic [3:0]      nb;
  logic [3:0]      nsum;
  logic            ncout;

  assign na = opa[4*idx +: 4];
  assign nb = opb[4*idx +: 4];

  select_adder_4 u_slice (
    .a    (na),
    .b    (nb),
    .cin  (carry),
    .s    (nsum),
    .cout (ncout)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      idx   <= '0;
      carry <= 1'b0;
      opa   <= '0;
      opb   <= '0;
      S     <= '0;
      cout  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            opa   <= A;
            opb   <= B;
            carry <= cin;
            idx   <= '0;
            S     <= '0;
            cout  <= 1'b0;
            busy  <= 1'b1;
            state <= ADD;
          end else begin
            state <= IDLE;
          end
        end
        ADD: begin
          S[4*idx +: 4] <= nsum;
          carry         <= ncout;
          if (idx == LAST) begin
            // idx parks at 0 so it never runs past the last nibble.
            idx   <= '0;
            cout  <= ncout;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder: vector table, hand sequences for the
// multi-cycle corners, and random operands against plain arithmetic.
module tb_nibble_serial_adder;
  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] A = '0;
  logic [15:0] B = '0;
  logic        cin = 1'b0;
  logic [15:0] S;
  logic        cout;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  nibble_serial_adder #(.WIDTH(16)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .start (start),
    .A     (A),
    .B     (B),
    .cin   (cin),
    .S     (S),
    .cout  (cout),
    .busy  (busy),
    .done  (done)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic [15:0] s;
    logic        co;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Launch one add and check latency, busy length, result and done width.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        input logic ci, input logic [15:0] es,
                        input logic ec);
    int n;
    int bc;
    @(negedge Clk);
    A = a; B = b; cin = ci; start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    A = 16'($urandom); B = 16'($urandom); cin = 1'($urandom);
    n = 0; bc = 0;
    while (!done && n < 20) begin
      if (busy) bc++;
      @(negedge Clk);
      n++;
    end
    check("latency", n, 4);
    check("busy_cycles", bc, 4);
    check("sum", int'(S), int'(es));
    check("cout", int'(cout), int'(ec));
    @(negedge Clk);
    check("done_pulse", int'(done), 0);
    check("sum_held", int'(S), int'(es));
  endtask

  initial begin
    vec_t vecs[5];
    logic [15:0] ra, rb;
    logic        rc;
    logic [16:0] full;
    int          cnt;
    int          m;

    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
    vecs[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    vecs[3] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0};
    vecs[4] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0};

    #2;
    check("rst_S", int'(S), 0);
    check("rst_cout", int'(cout), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    @(negedge Clk);
    Reset = 1'b0;

    for (int i = 0; i < 5; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].s, vecs[i].co);

    // Start during ADD must be ignored; exactly one done pulse.
    @(negedge Clk);
    A = 16'h00F0; B = 16'h0010; cin = 1'b0; start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    @(negedge Clk);
    A = 16'h7777; B = 16'h7777; start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) begin
        cnt++;
        check("busy_ign_S", int'(S), 16'h0100);
        check("busy_ign_cout", int'(cout), 0);
      end
      @(negedge Clk);
    end
    check("busy_ign_pulses", cnt, 1);

    // Reset in the middle of an add.
    @(negedge Clk);
    A = 16'h1111; B = 16'h1111; cin = 1'b0; start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b1;
    #1;
    check("midrst_S", int'(S), 0);
    check("midrst_cout", int'(cout), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    @(negedge Clk);
    Reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (done || busy) cnt++;
      @(negedge Clk);
    end
    check("midrst_idle", cnt, 0);
    run_op(16'h0A0A, 16'h0505, 1'b0, 16'h0F0F, 1'b0);

    // Start held through DONE: second op accepted without a dead cycle.
    @(negedge Clk);
    A = 16'h1111; B = 16'h2222; cin = 1'b0; start = 1'b1;
    m = 0;
    @(negedge Clk);
    while (!done && m < 20) begin
      @(negedge Clk);
      m++;
    end
    check("b2b_first_S", int'(S), 16'h3333);
    check("b2b_first_done", int'(done), 1);
    A = 16'h8000; B = 16'h8000;
    m = 0;
    @(negedge Clk);
    m++;
    start = 1'b0;
    while (!done && m < 20) begin
      @(negedge Clk);
      m++;
    end
    check("b2b_gap", m, 5);
    check("b2b_second_S", int'(S), 0);
    check("b2b_second_cout", int'(cout), 1);

    for (int i = 0; i < 30; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      full = {1'b0, ra} + {1'b0, rb} + {16'd0, rc};
      run_op(ra, rb, rc, full[15:0], full[16]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
